// File: rtl/fxp_seq_alu_if.sv
// Operation bus between the calculator input logic and the fixed-point ALU core.
interface fxp_seq_alu_if #(
  parameter int unsigned W = 8
);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         neg;
  logic         ovf;
  logic         dz;
  logic         busy;
  logic         done;

  modport master (
    output start, op, a, b,
    input  result, neg, ovf, dz, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output result, neg, ovf, dz, busy, done
  );
endinterface

// File: rtl/fxp_seq_alu.sv
// Unsigned UQ(W-F).F sequential ALU: single-cycle ADD/SUB, bit-serial MUL and restoring DIV.
// Optional build macro SATURATE_EN clamps overflowed results to all-ones instead of wrapping.
module fxp_seq_alu #(
  parameter int unsigned W = 8,
  parameter int unsigned F = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fxp_seq_alu_if.slave bus
);
  localparam int unsigned PW = 2 * W;
  localparam int unsigned QW = W + F;
  localparam int unsigned CW = $clog2(W + F + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t        state, state_d;
  op_t           op_q, op_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0] prod_q, prod_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  result_q, result_d;
  logic          neg_q, neg_d, ovf_q, ovf_d, dz_q, dz_d, busy_q, busy_d, done_q, done_d;

  logic [W:0]    add_sum, mul_sum, rem_sh;
  logic [W-1:0]  sub_mag, raw;
  logic          raw_neg, raw_ovf, raw_dz, q_bit;

  // Iteration datapath: one partial-product add and one trial subtraction per clock.
  assign add_sum = {1'b0, a_q} + {1'b0, b_q};
  assign sub_mag = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
  assign mul_sum = {1'b0, prod_q[PW-1:W]} + (prod_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
  assign rem_sh  = {rem_q, quo_q[QW-1]};
  assign q_bit   = (rem_sh >= {1'b0, b_q});

  // Final result and flag selection, evaluated while in DONE.
  always_comb begin
    raw     = '0;
    raw_neg = 1'b0;
    raw_ovf = 1'b0;
    raw_dz  = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        raw     = add_sum[W-1:0];
        raw_ovf = add_sum[W];
      end
      OP_SUB: begin
        raw     = sub_mag;
        raw_neg = (a_q < b_q);
      end
      OP_MUL: begin
        raw     = prod_q[W+F-1:F];
        raw_ovf = ((prod_q >> (W + F)) != '0);
      end
      OP_DIV: begin
        if (b_q == '0) begin
          raw    = '1;
          raw_dz = 1'b1;
        end else begin
          raw     = quo_q[W-1:0];
          raw_ovf = ((quo_q >> W) != '0);
        end
      end
      default: ;
    endcase
`ifdef SATURATE_EN
    if (raw_ovf) raw = '1;
`else
    raw = raw;
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          op_d   = op_t'(bus.op);
          a_d    = bus.a;
          b_d    = bus.b;
          neg_d  = 1'b0;
          ovf_d  = 1'b0;
          dz_d   = 1'b0;
          prod_d = PW'(bus.b);
          quo_d  = QW'(bus.a) << F;
          rem_d  = '0;
          state_d = S_DONE;
          if (op_t'(bus.op) == OP_MUL) begin
            state_d = S_MUL;
            cnt_d   = CW'(W - 1);
            busy_d  = 1'b1;
          end else if (op_t'(bus.op) == OP_DIV && bus.b != '0) begin
            state_d = S_DIV;
            cnt_d   = CW'(W + F - 1);
            busy_d  = 1'b1;
          end
        end
      end
      S_MUL: begin
        prod_d = PW'({mul_sum, prod_q[W-1:0]} >> 1);
        cnt_d  = CW'(cnt_q - 1'b1);
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
        end
      end
      S_DIV: begin
        rem_d  = q_bit ? W'(rem_sh - {1'b0, b_q}) : rem_sh[W-1:0];
        quo_d  = (quo_q << 1) | QW'(q_bit);
        cnt_d  = CW'(cnt_q - 1'b1);
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
        end
      end
      S_DONE: begin
        result_d = raw;
        neg_d    = raw_neg;
        ovf_d    = raw_ovf;
        dz_d     = raw_dz;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.neg    = neg_q;
  assign bus.ovf    = ovf_q;
  assign bus.dz     = dz_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_fxp_seq_alu.sv
// Directed bench for fxp_seq_alu at W=8, F=4; expected values are hand-computed UQ4.4 results.
module tb_fxp_seq_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  fxp_seq_alu_if #(.W(8)) bus ();

  fxp_seq_alu #(.W(8), .F(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for done; lat = -1 on timeout.
  task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output int bcnt, output logic [7:0] r,
                        output logic n, output logic v, output logic z);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 2'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
    lat = 0;
    bcnt = bus.busy ? 1 : 0;
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (!bus.done && bus.busy) bcnt++;
    end
    if (!bus.done) lat = -1;
    r = bus.result; n = bus.neg; v = bus.ovf; z = bus.dz;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 2'b00; bus.a = 8'h00; bus.b = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.result, bus.neg, bus.ovf, bus.dz, bus.busy, bus.done} !== 13'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {bus.result, bus.neg, bus.ovf, bus.dz, bus.busy, bus.done});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat, bc; logic [7:0] r; logic n, v, z;
    run_op(2'b00, 8'h50, 8'h30, lat, bc, r, n, v, z);
    checks++; if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end
    checks++; if ({r, n, v, z} !== {8'h80, 3'b000}) begin failures++; $display("FAIL add_50_30 got=%h/%b%b%b exp=80/000", r, n, v, z); end
    run_op(2'b00, 8'hF0, 8'h20, lat, bc, r, n, v, z);
    checks++; if ({r, n, v, z} !== {(SAT ? 8'hFF : 8'h10), 3'b010}) begin failures++; $display("FAIL add_ovf got=%h/%b%b%b exp=%h/010", r, n, v, z, SAT ? 8'hFF : 8'h10); end
    run_op(2'b00, 8'h7F, 8'h80, lat, bc, r, n, v, z);
    checks++; if ({r, n, v, z} !== {8'hFF, 3'b000}) begin failures++; $display("FAIL add_max_no_ovf got=%h/%b%b%b exp=FF/000", r, n, v, z); end
    run_op(2'b00, 8'hFF, 8'h01, lat, bc, r, n, v, z);
    checks++; if ({r, n, v, z} !== {(SAT ? 8'hFF : 8'h00), 3'b010}) begin failures++; $display("FAIL add_carry got=%h/%b%b%b exp=%h/010", r, n, v, z, SAT ? 8'hFF : 8'h00); end
  endtask

  task automatic test_sub();
    int lat, bc; logic [7:0] r; logic n, v, z;
    run_op(2'b01, 8'h30, 8'h50, lat, bc, r, n, v, z);
    checks++; if (lat !== 1) begin failures++; $display("FAIL sub_latency got=%0d exp=1", lat); end
    checks++; if ({r, n, v, z} !== {8'h20, 3'b100}) begin failures++; $display("FAIL sub_neg got=%h/%b%b%b exp=20/100", r, n, v, z); end
    run_op(2'b01, 8'h50, 8'h50, lat, bc, r, n, v, z);
    checks++; if ({r, n, v, z} !== {8'h00, 3'b000}) begin failures++; $display("FAIL sub_equal got=%h/%b%b%b exp=00/000", r, n, v, z); end
    run_op(2'b01, 8'h00, 8'hFF, lat, bc, r, n, v, z);
    checks++; if ({r, n, v, z} !== {8'hFF, 3'b100}) begin failures++; $display("FAIL sub_extreme got=%h/%b%b%b exp=FF/100", r, n, v, z); end
    run_op(2'b01, 8'hC3, 8'h41, lat, bc, r, n, v, z);
    checks++; if ({r, n, v, z} !== {8'h82, 3'b000}) begin failures++; $display("FAIL sub_pos got=%h/%b%b%b exp=82/000", r, n, v, z); end
  endtask

  task automatic test_mul();
    int lat, bc; logic [7:0] r; logic n, v, z;
    run_op(2'b10, 8'h40, 8'h28, lat, bc, r, n, v, z);
    checks++; if (lat !== 9) begin failures++; $display("FAIL mul_latency got=%0d exp=9", lat); end
    checks++; if (bc !== 8) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=8", bc); end
    checks++; if ({r, n, v, z} !== {8'hA0, 3'b000}) begin failures++; $display("FAIL mul_40_28 got=%h/%b%b%b exp=A0/000", r, n, v, z); end
    run_op(2'b10, 8'hF0, 8'h20, lat, bc, r, n, v, z);
    checks++; if ({r, n, v, z} !== {(SAT ? 8'hFF : 8'hE0), 3'b010}) begin failures++; $display("FAIL mul_ovf got=%h/%b%b%b exp=%h/010", r, n, v, z, SAT ? 8'hFF : 8'hE0); end
    run_op(2'b10, 8'h10, 8'h10, lat, bc, r, n, v, z);
    checks++; if ({r, n, v, z} !== {8'h10, 3'b000}) begin failures++; $display("FAIL mul_one got=%h/%b%b%b exp=10/000", r, n, v, z); end
    run_op(2'b10, 8'hFF, 8'hFF, lat, bc, r, n, v, z);
    checks++; if ({r, n, v, z} !== {(SAT ? 8'hFF : 8'hE0), 3'b010}) begin failures++; $display("FAIL mul_max got=%h/%b%b%b exp=%h/010", r, n, v, z, SAT ? 8'hFF : 8'hE0); end
    run_op(2'b10, 8'h18, 8'h0C, lat, bc, r, n, v, z);
    checks++; if ({r, n, v, z} !== {8'h12, 3'b000}) begin failures++; $display("FAIL mul_frac got=%h/%b%b%b exp=12/000", r, n, v, z); end
  endtask

  task automatic test_div();
    int lat, bc; logic [7:0] r; logic n, v, z;
    run_op(2'b11, 8'h90, 8'h30, lat, bc, r, n, v, z);
    checks++; if (lat !== 13) begin failures++; $display("FAIL div_latency got=%0d exp=13", lat); end
    checks++; if (bc !== 12) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=12", bc); end
    checks++; if ({r, n, v, z} !== {8'h30, 3'b000}) begin failures++; $display("FAIL div_90_30 got=%h/%b%b%b exp=30/000", r, n, v, z); end
    run_op(2'b11, 8'h10, 8'h30, lat, bc, r, n, v, z);
    checks++; if ({r, n, v, z} !== {8'h05, 3'b000}) begin failures++; $display("FAIL div_trunc got=%h/%b%b%b exp=05/000", r, n, v, z); end
    run_op(2'b11, 8'hF0, 8'h01, lat, bc, r, n, v, z);
    checks++; if ({r, n, v, z} !== {(SAT ? 8'hFF : 8'h00), 3'b010}) begin failures++; $display("FAIL div_ovf got=%h/%b%b%b exp=%h/010", r, n, v, z, SAT ? 8'hFF : 8'h00); end
  endtask

  task automatic test_div_zero();
    int lat, bc; logic [7:0] r; logic n, v, z;
    run_op(2'b11, 8'h70, 8'h00, lat, bc, r, n, v, z);
    checks++; if (lat !== 1) begin failures++; $display("FAIL dz_latency got=%0d exp=1", lat); end
    checks++; if ({r, n, v, z} !== {8'hFF, 3'b001}) begin failures++; $display("FAIL dz_result got=%h/%b%b%b exp=FF/001", r, n, v, z); end
  endtask

  task automatic test_ignore_start();
    int lat; int extra;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 8'h40; bus.b = 8'h28;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin bus.start = 1'b1; bus.op = 2'b00; bus.a = 8'h01; bus.b = 8'h01; end
      else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    checks++; if (lat !== 9) begin failures++; $display("FAIL ignore_latency got=%0d exp=9", lat); end
    checks++; if ({bus.result, bus.ovf} !== {8'hA0, 1'b0}) begin failures++; $display("FAIL ignore_result got=%h/%b exp=A0/0", bus.result, bus.ovf); end
    extra = 0;
    repeat (4) begin @(negedge clk); if (bus.done || bus.busy) extra++; end
    checks++; if (extra !== 0) begin failures++; $display("FAIL ignore_no_requeue got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    int lat, bc; logic [7:0] r; logic n, v, z;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 8'h90; bus.b = 8'h30;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", bus.busy); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.result, bus.neg, bus.ovf, bus.dz, bus.busy, bus.done} !== 13'h0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%h exp=0", {bus.result, bus.neg, bus.ovf, bus.dz, bus.busy, bus.done});
    end
    rst_n = 1'b1;
    run_op(2'b00, 8'h50, 8'h30, lat, bc, r, n, v, z);
    checks++; if (lat !== 1) begin failures++; $display("FAIL post_reset_latency got=%0d exp=1", lat); end
    checks++; if ({r, n, v, z} !== {8'h80, 3'b000}) begin failures++; $display("FAIL post_reset_add got=%h/%b%b%b exp=80/000", r, n, v, z); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic [7:0] r; logic n, v, z;
    run_op(2'b01, 8'h20, 8'h90, lat, bc, r, n, v, z);
    checks++; if ({r, n} !== {8'h70, 1'b1}) begin failures++; $display("FAIL b2b_sub got=%h/%b exp=70/1", r, n); end
    run_op(2'b10, 8'h20, 8'h30, lat, bc, r, n, v, z);
    checks++; if ({r, n, v, z} !== {8'h60, 3'b000}) begin failures++; $display("FAIL b2b_mul_clears_neg got=%h/%b%b%b exp=60/000", r, n, v, z); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL b2b_done_pulse got=%b exp=0", bus.done); end
    checks++; if (bus.result !== 8'h60) begin failures++; $display("FAIL b2b_result_held got=%h exp=60", bus.result); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
